// File: rtl/maze_pkg.sv
// Shared types and default timing constants for the maze button front end.
// Defaults assume a 100 MHz clk.
// No logic; imported by the button FSM and its wrapper.
package maze_pkg;

  // Per-button debounce/pulse FSM states
  typedef enum logic [2:0] {
    INI      = 3'd0,
    WQ       = 3'd1,
    SCEN_ST  = 3'd2,
    MCEN_CNT = 3'd3,
    MCEN_ST  = 3'd4,
    CCEN_CNT = 3'd5,
    CCEN_ST  = 3'd6,
    WFCR     = 3'd7
  } btn_state_t;

  localparam int unsigned DEF_NUM_BTNS     = 4;
  localparam int unsigned DEF_DEB_CYCLES   = 1_000_000;   // 10 ms
  localparam int unsigned DEF_MCEN_DELAY   = 25_000_000;  // 250 ms
  localparam int unsigned DEF_MCEN_REPEATS = 4;
  localparam int unsigned DEF_CCEN_PERIOD  = 2_500_000;   // 25 ms

  // Largest of three periods; sizes the shared per-button counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// Single-button synchronizer + debounce/pulse FSM producing DPB/SCEN/MCEN/CCEN.
// Latency: 2 sync edges + DEB_CYCLES to the first pulse; outputs decode the state register.
// No backpressure: pulses are fire-and-forget single-cycle enables.
module btn_debounce_fsm
  import maze_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned MCEN_DELAY   = DEF_MCEN_DELAY,
  parameter int unsigned MCEN_REPEATS = DEF_MCEN_REPEATS,
  parameter int unsigned CCEN_PERIOD  = DEF_CCEN_PERIOD
) (
  input  logic clk,
  input  logic Reset,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen
);

  localparam int unsigned CNT_MAX = max3(DEB_CYCLES, MCEN_DELAY, CCEN_PERIOD);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned REP_W   = $clog2(MCEN_REPEATS + 1);

  // Terminal counts; every compare fires before the counter could wrap
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] MCEN_LAST = CNT_W'(MCEN_DELAY - 1);
  localparam logic [CNT_W-1:0] CCEN_LAST = CNT_W'(CCEN_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(MCEN_REPEATS);

  logic             pb_meta;
  logic             pb_s;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_nxt;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc = rep + REP_ONE;

  // Two-flop synchronizer for the raw, asynchronous button level
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pb_meta <= 1'b0;
      pb_s    <= 1'b0;
    end else begin
      pb_meta <= pb;
      pb_s    <= pb_meta;
    end
  end

  // State, period counter and repeat counter registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= INI;
      cnt   <= '0;
      rep   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rep   <= rep_nxt;
    end
  end

  // Next-state logic; pulse states ignore pb_s, release is caught in the *_CNT states
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rep_nxt   = rep;
    case (state)
      INI: begin
        cnt_nxt = '0;
        rep_nxt = '0;
        if (pb_s) state_nxt = WQ;
      end
      WQ: begin
        if (!pb_s) begin
          state_nxt = INI;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = SCEN_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      SCEN_ST: begin
        rep_nxt   = REP_ONE;
        cnt_nxt   = '0;
        state_nxt = (MCEN_REPEATS == 1) ? CCEN_CNT : MCEN_CNT;
      end
      MCEN_CNT: begin
        if (!pb_s) begin
          state_nxt = WFCR;
          cnt_nxt   = '0;
        end else if (cnt == MCEN_LAST) begin
          state_nxt = MCEN_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      MCEN_ST: begin
        rep_nxt   = rep_inc;
        cnt_nxt   = '0;
        state_nxt = (rep_inc == REP_LAST) ? CCEN_CNT : MCEN_CNT;
      end
      CCEN_CNT: begin
        if (!pb_s) begin
          state_nxt = WFCR;
          cnt_nxt   = '0;
        end else if (cnt == CCEN_LAST) begin
          state_nxt = CCEN_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      CCEN_ST: begin
        cnt_nxt   = '0;
        state_nxt = CCEN_CNT;
      end
      WFCR: begin
        if (pb_s) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = INI;
          cnt_nxt   = '0;
          rep_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = INI;
        cnt_nxt   = '0;
        rep_nxt   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    dpb  = 1'b0;
    scen = 1'b0;
    mcen = 1'b0;
    ccen = 1'b0;
    case (state)
      SCEN_ST: begin
        dpb  = 1'b1;
        scen = 1'b1;
        mcen = 1'b1;
        ccen = 1'b1;
      end
      MCEN_ST: begin
        dpb  = 1'b1;
        mcen = 1'b1;
        ccen = 1'b1;
      end
      CCEN_ST: begin
        dpb  = 1'b1;
        ccen = 1'b1;
      end
      MCEN_CNT, CCEN_CNT, WFCR: dpb = 1'b1;
      default: dpb = 1'b0;
    endcase
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Board push-buttons to debounced levels and SCEN/MCEN/CCEN movement enables.
// Latency: 2 sync edges + DEB_CYCLES to first pulse; buttons fully independent.
// No backpressure: consumer must take each single-cycle enable when it appears.
module btn_pulse_gen
  import maze_pkg::*;
#(
  parameter int unsigned NUM_BTNS     = DEF_NUM_BTNS,
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned MCEN_DELAY   = DEF_MCEN_DELAY,
  parameter int unsigned MCEN_REPEATS = DEF_MCEN_REPEATS,
  parameter int unsigned CCEN_PERIOD  = DEF_CCEN_PERIOD
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [NUM_BTNS-1:0] PB,
  output logic [NUM_BTNS-1:0] DPB,
  output logic [NUM_BTNS-1:0] SCEN,
  output logic [NUM_BTNS-1:0] MCEN,
  output logic [NUM_BTNS-1:0] CCEN
);

  // One independent FSM per button bit {up, down, left, right}
  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce_fsm #(
      .DEB_CYCLES  (DEB_CYCLES),
      .MCEN_DELAY  (MCEN_DELAY),
      .MCEN_REPEATS(MCEN_REPEATS),
      .CCEN_PERIOD (CCEN_PERIOD)
    ) u_fsm (
      .clk  (clk),
      .Reset(Reset),
      .pb   (PB[g]),
      .dpb  (DPB[g]),
      .scen (SCEN[g]),
      .mcen (MCEN[g]),
      .ccen (CCEN[g])
    );
  end

endmodule

// File: doc/btn_pulse_gen.md
# btn_pulse_gen

Converts the raw Basys/Nexys push-buttons (up, down, left, right) into clean, single-cycle control pulses for the maze game logic. One debounce/pulse FSM per button produces a debounced level (DPB), a single-clock enable on press (SCEN), a multi-clock enable that repeats while held (MCEN), and a continuous-clock enable for long holds (CCEN). It sits between the board pins in the top level and the game-logic movement block, which consumes one SCEN/MCEN pulse per grid step.

## Interface
- NUM_BTNS, 4, number of independent buttons; bit order {up, down, left, right} = [3:0]
- DEB_CYCLES, 1_000_000, stable cycles required to accept a press or a release (≥2)
- MCEN_DELAY, 25_000_000, cycles between consecutive MCEN pulses while held (≥2)
- MCEN_REPEATS, 4, number of MCEN pulses (including the SCEN-cycle pulse) before entering continuous mode (≥1)
- CCEN_PERIOD, 2_500_000, cycles between CCEN pulses in continuous mode (≥2)
- clk  in  1  system clock
- Reset  in  1  asynchronous, active-high; clock clk
- PB  in  NUM_BTNS  raw asynchronous button levels, active-high
- DPB  out  NUM_BTNS  debounced button level
- SCEN  out  NUM_BTNS  one-cycle pulse per accepted press
- MCEN  out  NUM_BTNS  one-cycle pulses: at press, then every MCEN_DELAY while held, up to MCEN_REPEATS total
- CCEN  out  NUM_BTNS  one-cycle pulses: with every SCEN/MCEN, then every CCEN_PERIOD while held

## Operation
- Each PB bit passes a 2-flop synchronizer (pb_s); the FSM sees only pb_s.
- Per-button Moore FSM, one counter cnt (width $clog2 of the largest period), one repeat counter rep:
- INI: all outputs 0, cnt=0, rep=0. pb_s=1 → WQ.
- WQ (debounce press): pb_s=0 → INI. cnt==DEB_CYCLES-1 → SCEN_ST (cnt=0), else cnt++.
- SCEN_ST: DPB=SCEN=MCEN=CCEN=1 for one cycle; rep=1. Unconditionally → MCEN_CNT (if MCEN_REPEATS==1 → CCEN_CNT).
- MCEN_CNT: DPB=1. pb_s=0 → WFCR (cnt=0). cnt==MCEN_DELAY-1 → MCEN_ST (cnt=0), else cnt++.
- MCEN_ST: DPB=MCEN=CCEN=1 one cycle; rep++. New rep==MCEN_REPEATS → CCEN_CNT, else → MCEN_CNT.
- CCEN_CNT: DPB=1. pb_s=0 → WFCR (cnt=0). cnt==CCEN_PERIOD-1 → CCEN_ST (cnt=0), else cnt++.
- CCEN_ST: DPB=CCEN=1 one cycle → CCEN_CNT.
- WFCR (debounce release): DPB=1. pb_s=1 → cnt=0, stay. cnt==DEB_CYCLES-1 → INI, else cnt++.
- Release during a pulse state is ignored for that cycle; detected in the following *_CNT state.
- Buttons are fully independent; simultaneous presses yield simultaneous pulses on each bit, no priority.
- Counters never wrap: every compare terminates before overflow.
- Unused state encodings → INI.

## Timing
- Reset (async): synchronizers cleared, FSMs to INI, all outputs 0 immediately; reset mid-hold discards progress, a still-held button must re-debounce after release of Reset.
- Outputs decoded from state register only; no combinational PB→output path.
- Raw PB high and stable from sampling edge 0: pb_s=1 after edge 1, WQ entered edge 2, SCEN_ST entered edge DEB_CYCLES+2; SCEN high in the cycle after that edge.
- Subsequent MCEN pulses spaced MCEN_DELAY+1 cycles (pulse-to-pulse); CCEN pulses in continuous mode spaced CCEN_PERIOD+1.
- DPB falls DEB_CYCLES+2 edges after raw release (sync + WFCR), provided no bounce.
- Glitch shorter than DEB_CYCLES in WQ: no output activity.

## Structure
- Shared package maze_pkg: state enum (INI, WQ, SCEN_ST, MCEN_CNT, MCEN_ST, CCEN_CNT, CCEN_ST, WFCR) and default period constants for 100 MHz.
- Sub-module btn_debounce_fsm (single button: synchronizer, FSM, counters); btn_pulse_gen is a generate loop of NUM_BTNS instances.

## Test plan
Params DEB_CYCLES=4, MCEN_DELAY=8, MCEN_REPEATS=3, CCEN_PERIOD=2.
- Raw PB[0] high 3 cycles then low → DPB/SCEN/MCEN/CCEN stay 0 throughout.
- PB[1] held high 12 cycles, released → exactly one SCEN[1] pulse at cycle 7 after first sampling edge, DPB[1] high from cycle 7 until 6 edges after release.
- PB[2] held 60 cycles → MCEN[2] pulses at cycles 7, 16, 25 only; CCEN[2] at 7, 16, 25, then every 3 cycles (28, 31, ...).
- Release with bounce (low 2, high 1, low stable) in WFCR → cnt restarts, DPB stays 1 until 4 stable-low samples, no new SCEN.
- PB[0] and PB[3] pressed same cycle → SCEN[0] and SCEN[3] assert same cycle.
- Reset asserted while PB[2] in CCEN_CNT → all outputs 0 at once; after Reset drops with PB still high, SCEN[2] reappears DEB_CYCLES+2 edges later.
